// File: rtl/spi_byte_rx.sv
// spi_byte_rx: SPI mode-0 slave byte receiver, oversampled in the clk_i domain.
// Synchronises the SPI pins, shifts in bytes, and emits byte/abort strobes.
//
// Ports:
//   clk_i, rst_n_i    system clock, asynchronous active-low reset
//   spi_sclk_i        SPI clock pin (async)
//   spi_mosi_i        SPI data pin (async)
//   spi_cs_n_i        SPI chip select, active low (async)
//   spi_dc_i          data/command pin, 0 = command, 1 = data (async)
//   dc_o              D/C flag of the last completed byte
//   spi_byte_vld_o    1-cycle strobe, byte complete
//   spi_byte_data_o   last completed byte
//   spi_abort_o       1-cycle strobe, CS released with a partial byte
//
// Parameters:
//   SYNC_STAGES       depth of each pin synchroniser (2..4)
//
// Build option:
//   SPI_RX_LSB_FIRST_EN  when defined, the first bit received lands in bit 0.
//                        Undefined (default): MSB first.

module spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       spi_sclk_i,
    input  logic       spi_mosi_i,
    input  logic       spi_cs_n_i,
    input  logic       spi_dc_i,
    output logic       dc_o,
    output logic       spi_byte_vld_o,
    output logic [7:0] spi_byte_data_o,
    output logic       spi_abort_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // All four pins use the same depth so their relative skew is preserved.
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] dc_sync_q;

    logic sclk_s;
    logic mosi_s;
    logic cs_n_s;
    logic dc_s;

    logic sclk_dly_q;
    logic sclk_rise;

    logic [2:0] bit_cnt_q;
    logic [7:0] shreg_q;
    logic [7:0] shreg_nxt;
    logic       done_q;
    logic       dc_cap_q;

    logic shift_en;
    logic cnt_clr;
    logic abort_d;
    logic last_bit;

    // ------------------------------------------------------------------
    // Pin synchronisers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            dc_sync_q   <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
            dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], spi_dc_i};
        end
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign cs_n_s = cs_sync_q[SYNC_STAGES-1];
    assign dc_s   = dc_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // SCLK rising-edge detect
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sclk_dly_q <= 1'b0;
        end else begin
            sclk_dly_q <= sclk_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_dly_q;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A CS release seen in the same cycle as a rise wins: the rise is
    // dropped and any partial byte becomes an abort.
    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        cnt_clr  = 1'b0;
        abort_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!cs_n_s) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                if (cs_n_s) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                    abort_d = (bit_cnt_q != 3'd0);
                end else if (sclk_rise) begin
                    shift_en = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shift register and bit counter
    // ------------------------------------------------------------------
`ifdef SPI_RX_LSB_FIRST_EN
    assign shreg_nxt = {mosi_s, shreg_q[7:1]};
`else
    assign shreg_nxt = {shreg_q[6:0], mosi_s};
`endif

    assign last_bit = shift_en && (bit_cnt_q == 3'd7);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bit_cnt_q <= 3'd0;
            shreg_q   <= 8'h00;
            done_q    <= 1'b0;
            dc_cap_q  <= 1'b0;
        end else begin
            done_q <= last_bit;
            if (cnt_clr) begin
                bit_cnt_q <= 3'd0;
                shreg_q   <= 8'h00;
            end else if (shift_en) begin
                // Counter wraps 7 -> 0 so bytes can follow without a CS toggle.
                bit_cnt_q <= bit_cnt_q + 3'd1;
                shreg_q   <= shreg_nxt;
            end
            if (last_bit) begin
                dc_cap_q <= dc_s;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register: data and dc update together with the strobe and
    // then hold until the next completed byte.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            spi_byte_vld_o  <= 1'b0;
            spi_byte_data_o <= 8'h00;
            dc_o            <= 1'b0;
            spi_abort_o     <= 1'b0;
        end else begin
            spi_byte_vld_o <= done_q;
            spi_abort_o    <= abort_d;
            if (done_q) begin
                spi_byte_data_o <= shreg_q;
                dc_o            <= dc_cap_q;
            end
        end
    end

endmodule

// File: tb/tb_spi_byte_rx.sv
// tb_spi_byte_rx: directed bench for spi_byte_rx with a pin-level byte model.
// A negedge compare process checks every output on every cycle.

`timescale 1ns/1ps

module tb_spi_byte_rx;

    localparam int S = 2;

`ifdef SPI_RX_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       cs_n = 1'b1;
    logic       dc = 1'b0;
    logic       dc_o;
    logic       vld;
    logic [7:0] data;
    logic       abort;

    always #5 clk = ~clk;

    spi_byte_rx #(.SYNC_STAGES(S)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .spi_sclk_i     (sclk),
        .spi_mosi_i     (mosi),
        .spi_cs_n_i     (cs_n),
        .spi_dc_i       (dc),
        .dc_o           (dc_o),
        .spi_byte_vld_o (vld),
        .spi_byte_data_o(data),
        .spi_abort_o    (abort)
    );

    // Number of posedges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state, written only by the stimulus process.
    bit         bits[$];
    bit         exp_vld[int];
    logic [7:0] exp_data[int];
    logic       exp_dc[int];
    bit         exp_abort[int];
    logic [7:0] lit_data[int];
    logic       lit_dc[int];
    bit         done = 1'b0;

    // Counters, stepped only by the compare process.
    int vectors = 0;
    int miscompares = 0;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Byte value from the wire-order bit list.
    function automatic logic [7:0] pack(input bit q[$]);
        int v;
        v = 0;
        for (int i = 0; i < 8; i++) begin
            if (LSB) v = v + (int'(q[i]) << i);
            else     v = v + (int'(q[i]) << (7 - i));
        end
        return v[7:0];
    endfunction

    // Hand literal as it must appear on spi_byte_data_o for a byte sent MSB first.
    function automatic logic [7:0] on_bus(input logic [7:0] v);
        return LSB ? rev8(v) : v;
    endfunction

    // A pin change made now is first captured at posedge cyc+1.
    task automatic model_rise(input bit d);
        logic [7:0] v;
        bits.push_back(mosi);
        if (bits.size() == 8) begin
            v = pack(bits);
            exp_vld[cyc + S + 2]  = 1'b1;
            exp_data[cyc + S + 2] = v;
            exp_dc[cyc + S + 2]   = d;
            bits.delete();
        end
    endtask

    task automatic spi_bit(input bit b, input bit d);
        @(posedge clk); #1;
        sclk = 1'b0;
        mosi = b;
        dc   = d;
        repeat (4) @(posedge clk);
        #1;
        sclk = 1'b1;
        model_rise(d);
        repeat (3) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v, input bit d);
        for (int i = 7; i >= 0; i--) spi_bit(v[i], d);
    endtask

    task automatic cs_low();
        @(posedge clk); #1;
        cs_n = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic cs_high();
        @(posedge clk); #1;
        sclk = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cs_n = 1'b1;
        if (bits.size() != 0) exp_abort[cyc + S + 1] = 1'b1;
        bits.delete();
        repeat (8) @(posedge clk);
    endtask

    task automatic expect_lit(input logic [7:0] d, input logic dv);
        @(posedge clk); #1;
        lit_data[cyc] = d;
        lit_dc[cyc]   = dv;
    endtask

    // ------------------------------------------------------------------
    // Compare process
    // ------------------------------------------------------------------
    always @(negedge clk) begin : cmp
        logic [7:0] held_d;
        logic       held_dc;
        bit         ev;
        bit         ea;
        if (!rst_n) begin
            held_d  = 8'h00;
            held_dc = 1'b0;
        end
        ev = exp_vld.exists(cyc);
        ea = exp_abort.exists(cyc);
        if (ev) begin
            held_d  = exp_data[cyc];
            held_dc = exp_dc[cyc];
        end
        vectors++;
        if (vld !== ev) begin
            miscompares++;
            $display("FAIL vld cyc=%0d got %b want %b", cyc, vld, ev);
        end
        if (abort !== ea) begin
            miscompares++;
            $display("FAIL abort cyc=%0d got %b want %b", cyc, abort, ea);
        end
        if (data !== held_d) begin
            miscompares++;
            $display("FAIL data cyc=%0d got %h want %h", cyc, data, held_d);
        end
        if (dc_o !== held_dc) begin
            miscompares++;
            $display("FAIL dc cyc=%0d got %b want %b", cyc, dc_o, held_dc);
        end
        if (lit_data.exists(cyc)) begin
            vectors++;
            if (data !== lit_data[cyc] || dc_o !== lit_dc[cyc]) begin
                miscompares++;
                $display("FAIL literal cyc=%0d got %h/%b want %h/%b",
                         cyc, data, dc_o, lit_data[cyc], lit_dc[cyc]);
            end
        end
        if (done || cyc > 20000) begin
            if (!done) begin
                miscompares++;
                $display("FAIL timeout cyc=%0d got running want done", cyc);
            end
            foreach (exp_vld[k]) begin
                if (k > cyc) begin
                    miscompares++;
                    $display("FAIL pending_vld at=%0d got none want pulse", k);
                end
            end
            foreach (exp_abort[k]) begin
                if (k > cyc) begin
                    miscompares++;
                    $display("FAIL pending_abort at=%0d got none want pulse", k);
                end
            end
            $display("== %0d vectors applied, %0d miscompares ==",
                     vectors, miscompares);
            $finish;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        expect_lit(8'h00, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Single byte.
        cs_low();
        send_byte(8'h2A, 1'b0);
        repeat (10) @(posedge clk);
        expect_lit(on_bus(8'h2A), 1'b0);
        cs_high();

        // Three bytes in one frame.
        cs_low();
        send_byte(8'h2C, 1'b0);
        repeat (10) @(posedge clk);
        expect_lit(on_bus(8'h2C), 1'b0);
        send_byte(8'h11, 1'b1);
        repeat (10) @(posedge clk);
        expect_lit(on_bus(8'h11), 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (10) @(posedge clk);
        expect_lit(on_bus(8'h22), 1'b1);
        cs_high();

        // Partial byte then abort, then a clean byte.
        cs_low();
        spi_bit(1'b1, 1'b0);
        spi_bit(1'b0, 1'b0);
        spi_bit(1'b1, 1'b0);
        spi_bit(1'b1, 1'b0);
        spi_bit(1'b0, 1'b0);
        cs_high();
        expect_lit(on_bus(8'h22), 1'b1);
        cs_low();
        send_byte(8'hA5, 1'b0);
        repeat (10) @(posedge clk);
        expect_lit(on_bus(8'hA5), 1'b0);
        cs_high();

        // CS release coincident with the 8th rise: dropped, abort instead.
        cs_low();
        for (int i = 6; i >= 0; i--) spi_bit(i[0], 1'b1);
        @(posedge clk); #1;
        sclk = 1'b0;
        mosi = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        sclk = 1'b1;
        cs_n = 1'b1;
        exp_abort[cyc + S + 1] = 1'b1;
        bits.delete();
        repeat (8) @(posedge clk);
        expect_lit(on_bus(8'hA5), 1'b0);
        @(posedge clk); #1;
        sclk = 1'b0;
        repeat (6) @(posedge clk);
        cs_low();
        send_byte(8'h3C, 1'b1);
        repeat (10) @(posedge clk);
        expect_lit(on_bus(8'h3C), 1'b1);
        cs_high();

        // Reset in the middle of a byte.
        cs_low();
        for (int i = 0; i < 4; i++) spi_bit(1'b1, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        sclk  = 1'b0;
        bits.delete();
        exp_vld.delete();
        exp_data.delete();
        exp_dc.delete();
        exp_abort.delete();
        repeat (2) @(posedge clk);
        expect_lit(8'h00, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        send_byte(8'h5A, 1'b1);
        repeat (10) @(posedge clk);
        expect_lit(on_bus(8'h5A), 1'b1);
        cs_high();

        // Bit-order pin: 0x01 on the wire.
        cs_low();
        send_byte(8'h01, 1'b0);
        repeat (10) @(posedge clk);
        expect_lit(LSB ? 8'h80 : 8'h01, 1'b0);
        cs_high();

        repeat (10) @(posedge clk);
        #1;
        done = 1'b1;
    end

endmodule
